// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment driver with a tear-free pending/shadow buffer.
// Optional display blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  load,
  input  logic                  lz_blank,
`ifdef SEG7_BLINK_EN
  input  logic                  blink,
`endif
  output logic                  update_pending,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);

  typedef logic [DIGITS-1:0][3:0] word_t;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b1001000;
      4'hB: s = 7'b0001000;
      4'hC: s = 7'b0011000;
      4'hD: s = 7'b0111000;
      4'hE: s = 7'b1111110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  word_t             pend_q, pend_d, shad_q, shad_d;
  logic              upd_q, upd_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              ft_q, ft_d;

  logic              tick, wrap, zero_run;
  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        nib;

`ifdef SEG7_BLINK_EN
  localparam int CNT_W = $clog2(2*BLINK_FRAMES);
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
`endif

  always_comb begin
    tick    = (presc_q == PRE_W'(REFRESH_DIV-1));
    wrap    = tick && (idx_q == IDX_W'(DIGITS-1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

    pend_d = load ? word_t'(data_in) : pend_q;
    shad_d = wrap ? pend_q : shad_q;
    upd_d  = load ? 1'b1 : (wrap ? 1'b0 : upd_q);
    ft_d   = wrap;

    // Blanking looks at the buffer that will be on screen after this edge,
    // so the first digit of a new frame already sees the swapped word.
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int i = DIGITS-1; i > 0; i--) begin
      zero_run   = zero_run && (shad_d[i] == 4'h0);
      lz_mask[i] = zero_run;
    end
    nib = shad_d[idx_d];

`ifdef SEG7_BLINK_EN
    bcnt_d = bcnt_q;
    if (wrap) begin
      if (!blink || bcnt_q == CNT_W'(2*BLINK_FRAMES-1)) bcnt_d = '0;
      else                                              bcnt_d = bcnt_q + CNT_W'(1);
    end
`endif

    seg_d = seg_q;
    an_d  = an_q;
    if (tick) begin
      seg_d = (lz_blank && lz_mask[idx_d]) ? 7'b1111111 : decode(nib);
      an_d  = ~(DIGITS'(1) << idx_d);
`ifdef SEG7_BLINK_EN
      if (bcnt_d >= CNT_W'(BLINK_FRAMES)) begin
        seg_d = 7'b1111111;
        an_d  = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      pend_q  <= '1;
      shad_q  <= '1;
      upd_q   <= 1'b0;
      seg_q   <= 7'b1111111;
      an_q    <= ~DIGITS'(1);
      ft_q    <= 1'b0;
`ifdef SEG7_BLINK_EN
      bcnt_q  <= '0;
`endif
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      shad_q  <= shad_d;
      upd_q   <= upd_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      ft_q    <= ft_d;
`ifdef SEG7_BLINK_EN
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign update_pending = upd_q;
  assign seg            = seg_q;
  assign an             = an_q;
  assign frame_tick     = ft_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: table of loaded words with hand-written expected digits,
// checked through a scoreboard queue, plus reset, double-load and wrap-load sequences.
module tb_seg7_scan_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic        update_pending, frame_tick;
  logic [6:0]  seg;
  logic [3:0]  an;

  seg7_scan_driver #(.DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load(load), .lz_blank(lz_blank),
    .update_pending(update_pending), .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; logic lz; logic [3:0][6:0] exp; } vec_t;
  typedef struct { logic [3:0] an; logic [6:0] seg; } exp_t;

  vec_t vecs[8];
  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;

  localparam logic [6:0] BL = 7'b1111111;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_ft(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (frame_tick === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL frame_tick_timeout: got no pulse expected pulse within 64 cycles");
    end
  endtask

  task automatic push_frame(input logic [3:0][6:0] e);
    logic [3:0] one;
    exp_t x;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      x.an  = ~(one << d);
      x.seg = e[d];
      sbq.push_back(x);
    end
  endtask

  task automatic check_frame(input string name, input logic exp_upd);
    bit ok;
    exp_t x;
    wait_ft(ok);
    if (!ok) return;
    chk({name, "_upd_after_wrap"}, update_pending, exp_upd);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (4) @(negedge clk);
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL %s_scoreboard: got empty queue expected entry", name);
      end else begin
        x = sbq.pop_front();
        chk($sformatf("%s_an_d%0d", name, d), an, x.an);
        chk($sformatf("%s_seg_d%0d", name, d), seg, x.seg);
      end
    end
  endtask

  task automatic drive_load(input logic [15:0] v);
    data_in = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    bit ok;
    int ft_cnt;
    vecs[0] = '{16'h1234, 1'b0, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}};
    vecs[1] = '{16'h0070, 1'b1, {BL,         BL,         7'b0001111, 7'b0000001}};
    vecs[2] = '{16'h0000, 1'b1, {BL,         BL,         BL,         7'b0000001}};
    vecs[3] = '{16'hDBCA, 1'b0, {7'b0111000, 7'b0001000, 7'b0011000, 7'b1001000}};
    vecs[4] = '{16'h5678, 1'b0, {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}};
    vecs[5] = '{16'h9E0F, 1'b0, {7'b0000100, 7'b1111110, 7'b0000001, BL}};
    vecs[6] = '{16'h0070, 1'b0, {7'b0000001, 7'b0000001, 7'b0001111, 7'b0000001}};
    vecs[7] = '{16'h0A00, 1'b1, {BL,         7'b1001000, 7'b0000001, 7'b0000001}};

    // Reset release and scan cadence
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, BL);
    chk("rst_upd", update_pending, 1'b0);
    chk("rst_ft", frame_tick, 1'b0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    chk("scan_hold3", an, 4'b1110);
    @(negedge clk); chk("scan_d1", an, 4'b1101);
    repeat (4) @(negedge clk); chk("scan_d2", an, 4'b1011);
    repeat (4) @(negedge clk); chk("scan_d3", an, 4'b0111);
    repeat (4) @(negedge clk); chk("scan_wrap_an", an, 4'b1110);
    chk("scan_wrap_ft", frame_tick, 1'b1);
    ft_cnt = 0;
    repeat (32) begin @(negedge clk); ft_cnt += int'(frame_tick); end
    chk("ft_per_32", ft_cnt, 2);

    // Table-driven loads, each mid-frame
    for (int v = 0; v < 8; v++) begin
      wait_ft(ok);
      repeat (5) @(negedge clk);
      lz_blank = vecs[v].lz;
      drive_load(vecs[v].data);
      push_frame(vecs[v].exp);
      chk($sformatf("v%0d_upd_set", v), update_pending, 1'b1);
      check_frame($sformatf("v%0d", v), 1'b0);
    end

    // Two loads in one frame: last wins
    lz_blank = 1'b0;
    wait_ft(ok);
    repeat (2) @(negedge clk);
    drive_load(16'h1111);
    repeat (2) @(negedge clk);
    drive_load(16'h2222);
    push_frame({7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010});
    check_frame("dbl", 1'b0);

    // Load coincident with the wrap tick
    wait_ft(ok);
    repeat (3) @(negedge clk);
    drive_load(16'h4321);
    repeat (11) @(negedge clk);
    drive_load(16'h8888);
    push_frame({7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111});
    push_frame({7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000});
    check_frame("wrapld_old", 1'b1);
    check_frame("wrapld_new", 1'b0);

    // Asynchronous reset mid-scan
    wait_ft(ok);
    repeat (6) @(negedge clk);
    drive_load(16'h5555);
    chk("midrst_pre_an", an, 4'b1101);
    #2 reset = 1'b1;
    #1;
    chk("midrst_an", an, 4'b1110);
    chk("midrst_seg", seg, BL);
    chk("midrst_upd", update_pending, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_restart_an", an, 4'b1101);
    chk("midrst_blank_seg", seg, BL);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
